axil_mmio_responder: RTL and testbench

- AXI4-Lite slave (responder) that terminates the host PCIe AXI-Lite master channel (25-bit address, 32-bit data) and implements a bank of host-visible control/status registers.
- Sits beside the simulator shim on the same clock and serves host MMIO for board-level controls: resets, QSFP enables and debug.
- Handles AW/W independently with single outstanding write and read, byte strobes, RO status words and error responses.

---
 rtl/axil_mmio_responder.sv | 191 +++++++++++++++++++
 tb/tb_axil_mmio_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mmio_responder.sv
// axil_mmio_responder
// AXI4-Lite responder serving a bank of host-visible control/status registers
// (board resets, QSFP enables, debug). One write and one read may be
// outstanding at a time, and the two directions run independently.
//
// Address map (word index = addr[ADDR_WIDTH-1:2], addr[1:0] ignored):
//   0 .. NUM_REGS-1 : RW registers, byte-strobed writes
//   NUM_REGS        : status_in (RO)
//   NUM_REGS+1      : free-running cycle counter (RO)
//   other           : unmapped (DECERR)
//
// Ports:
//   clock, reset       design clock, asynchronous active-high reset
//   s_axil_aw*         write address channel
//   s_axil_w*          write data channel (32-bit data, 4-bit strobes)
//   s_axil_b*          write response channel
//   s_axil_ar*         read address channel
//   s_axil_r*          read data channel
//   regs_out           RW register contents, reg i at [32i+31:32i]
//   wr_pulse           one-cycle strobe per reg, set the cycle after a write
//   status_in          RO status word
module axil_mmio_responder #(
  parameter int          ADDR_WIDTH = 25,
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] RESET_VAL  = 32'h0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  input  logic [31:0]              s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  output logic [1:0]               s_axil_bresp,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic [NUM_REGS*32-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      wr_pulse,
  input  logic [31:0]              status_in
);

  localparam int             IDX_W      = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] COUNT_IDX  = IDX_W'(NUM_REGS + 1);
  localparam logic [1:0]     RESP_OKAY  = 2'b00;
  localparam logic [1:0]     RESP_SLV   = 2'b10;
  localparam logic [1:0]     RESP_DEC   = 2'b11;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           regs [NUM_REGS];
  logic [31:0]           cycle_cnt;

  logic                  aw_fire, w_fire, ar_fire, commit;
  logic [ADDR_WIDTH-1:0] aw_addr_eff;
  logic [31:0]           wd_eff;
  logic [3:0]            ws_eff;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  wr_is_ro;
  logic [31:0]           rd_data_nxt;
  logic [1:0]            rd_resp_nxt;

  assign s_axil_awready = !aw_held && !s_axil_bvalid;
  assign s_axil_wready  = !w_held && !s_axil_bvalid;
  assign s_axil_arready = !s_axil_rvalid;

  assign aw_fire = s_axil_awvalid && s_axil_awready;
  assign w_fire  = s_axil_wvalid && s_axil_wready;
  assign ar_fire = s_axil_arvalid && s_axil_arready;

  // A channel accepted this cycle is used directly so AW+W in the same
  // cycle commits without first passing through the holding registers.
  assign aw_addr_eff = aw_held ? awaddr_q : s_axil_awaddr;
  assign wd_eff      = w_held ? wdata_q : s_axil_wdata;
  assign ws_eff      = w_held ? wstrb_q : s_axil_wstrb;
  assign commit      = (aw_held || aw_fire) && (w_held || w_fire) && !s_axil_bvalid;

  assign wr_idx = aw_addr_eff[ADDR_WIDTH-1:2];
  assign rd_idx = s_axil_araddr[ADDR_WIDTH-1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr_eff[1:0], s_axil_araddr[1:0]};

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) wr_sel[i] = 1'b1;
    end
    wr_is_ro = (wr_idx == STATUS_IDX) || (wr_idx == COUNT_IDX);
  end

  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = RESP_DEC;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data_nxt = regs[i];
        rd_resp_nxt = RESP_OKAY;
      end
    end
    if (rd_idx == STATUS_IDX) begin
      rd_data_nxt = status_in;
      rd_resp_nxt = RESP_OKAY;
    end
    if (rd_idx == COUNT_IDX) begin
      rd_data_nxt = cycle_cnt;
      rd_resp_nxt = RESP_OKAY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      wr_pulse      <= '0;
    end else begin
      wr_pulse <= '0;
      if (aw_fire) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_axil_awaddr;
      end
      if (w_fire) begin
        w_held  <= 1'b1;
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (commit) begin
        s_axil_bvalid <= 1'b1;
        wr_pulse      <= wr_sel;
        s_axil_bresp  <= (|wr_sel) ? RESP_OKAY : (wr_is_ro ? RESP_SLV : RESP_DEC);
      end else if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_sel[i] && ws_eff[k]) regs[i][8*k +: 8] <= wd_eff[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
    end else if (ar_fire) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_data_nxt;
      s_axil_rresp  <= rd_resp_nxt;
    end else if (s_axil_rvalid && s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_axil_mmio_responder.sv
// Directed bench for axil_mmio_responder with a response scoreboard and a
// register model kept alongside the stimulus.
module tb_axil_mmio_responder;
  localparam int AW = 25;
  localparam int NR = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              s_axil_awvalid = 1'b0, s_axil_awready;
  logic [AW-1:0]     s_axil_awaddr = '0;
  logic              s_axil_wvalid = 1'b0, s_axil_wready;
  logic [31:0]       s_axil_wdata = '0;
  logic [3:0]        s_axil_wstrb = '0;
  logic              s_axil_bvalid, s_axil_bready = 1'b0;
  logic [1:0]        s_axil_bresp;
  logic              s_axil_arvalid = 1'b0, s_axil_arready;
  logic [AW-1:0]     s_axil_araddr = '0;
  logic              s_axil_rvalid, s_axil_rready = 1'b0;
  logic [31:0]       s_axil_rdata;
  logic [1:0]        s_axil_rresp;
  logic [NR*32-1:0]  regs_out;
  logic [NR-1:0]     wr_pulse;
  logic [31:0]       status_in = '0;

  always #5 clock = ~clock;

  axil_mmio_responder #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VAL(32'h0)) dut (
    .clock(clock), .reset(reset),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready), .s_axil_awaddr(s_axil_awaddr),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_wdata(s_axil_wdata),
    .s_axil_wstrb(s_axil_wstrb),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_bresp(s_axil_bresp),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready), .s_axil_araddr(s_axil_araddr),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready), .s_axil_rdata(s_axil_rdata),
    .s_axil_rresp(s_axil_rresp),
    .regs_out(regs_out), .wr_pulse(wr_pulse), .status_in(status_in)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model [NR];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];   // {rresp, rdata}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] exp_bresp(input logic [AW-1:0] a);
    int idx;
    idx = int'(a[AW-1:2]);
    if (idx < NR) return 2'b00;
    if (idx == NR || idx == NR + 1) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [33:0] exp_read(input logic [AW-1:0] a);
    int idx;
    idx = int'(a[AW-1:2]);
    if (idx < NR) return {2'b00, model[idx]};
    if (idx == NR) return {2'b00, status_in};
    return {2'b11, 32'h0};
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) check(tag, regs_out[32*i +: 32], model[i]);
  endtask

  // Applies a write to the model and scoreboard, returns the expected pulse.
  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [NR-1:0] pulse);
    int idx;
    idx   = int'(a[AW-1:2]);
    pulse = '0;
    exp_b_q.push_back(exp_bresp(a));
    if (idx < NR) begin
      for (int k = 0; k < 4; k++) if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      pulse[idx] = 1'b1;
    end
  endtask

  // Called #1 after the commit edge; bready is already 1.
  task automatic collect_b(input logic [NR-1:0] pulse);
    logic [1:0] eb;
    check("bvalid_rise", 32'(s_axil_bvalid), 32'd1);
    eb = exp_b_q.pop_front();
    check("bresp", 32'(s_axil_bresp), 32'(eb));
    check("wr_pulse", 32'(wr_pulse), 32'(pulse));
    check("awready_busy", 32'(s_axil_awready), 32'd0);
    step();
    check("bvalid_clear", 32'(s_axil_bvalid), 32'd0);
    check("wr_pulse_clear", 32'(wr_pulse), 32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [NR-1:0] pulse;
    int n;
    model_write(a, d, s, pulse);
    s_axil_awvalid = 1'b1; s_axil_awaddr = a;
    s_axil_wvalid  = 1'b1; s_axil_wdata  = d; s_axil_wstrb = s;
    s_axil_bready  = 1'b1;
    n = 0;
    while (!(s_axil_awready && s_axil_wready) && n < 20) begin step(); n++; end
    check("aw_w_accept_in_time", 32'(n < 20), 32'd1);
    step();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    collect_b(pulse);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold, input bit chk,
                         output logic [31:0] rd);
    logic [33:0] e;
    int n;
    e = '0;
    if (chk) exp_r_q.push_back(exp_read(a));
    s_axil_arvalid = 1'b1; s_axil_araddr = a; s_axil_rready = 1'b0;
    n = 0;
    while (!s_axil_arready && n < 20) begin step(); n++; end
    check("ar_accept_in_time", 32'(n < 20), 32'd1);
    step();
    s_axil_arvalid = 1'b0;
    check("rvalid_rise", 32'(s_axil_rvalid), 32'd1);
    rd = s_axil_rdata;
    if (chk) e = exp_r_q[0];
    for (int h = 0; h < hold; h++) begin
      step();
      check("rvalid_hold", 32'(s_axil_rvalid), 32'd1);
      check("arready_hold", 32'(s_axil_arready), 32'd0);
      if (chk) check("rdata_hold", s_axil_rdata, e[31:0]);
    end
    if (chk) begin
      e = exp_r_q.pop_front();
      check("rdata", s_axil_rdata, e[31:0]);
      check("rresp", 32'(s_axil_rresp), 32'(e[33:32]));
    end
    s_axil_rready = 1'b1;
    step();
    s_axil_rready = 1'b0;
    check("rvalid_clear", 32'(s_axil_rvalid), 32'd0);
    check("arready_free", 32'(s_axil_arready), 32'd1);
  endtask

  initial begin
    logic [31:0]   rd, c1, c2;
    logic [NR-1:0] pulse;

    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    check("rst_bresp", 32'(s_axil_bresp), 32'd0);
    check("rst_rresp", 32'(s_axil_rresp), 32'd0);
    check("rst_rdata", s_axil_rdata, 32'd0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check_regs("rst_regs");

    // AW and W together
    do_write(25'h004, 32'hDEADBEEF, 4'hF);
    check("reg1_after_write", regs_out[63:32], 32'hDEADBEEF);
    check_regs("regs_t1");

    // W three cycles ahead of AW
    model_write(25'h008, 32'h000000AA, 4'b0001, pulse);
    s_axil_bready = 1'b1;
    s_axil_wvalid = 1'b1; s_axil_wdata = 32'h000000AA; s_axil_wstrb = 4'b0001;
    check("w_first_wready", 32'(s_axil_wready), 32'd1);
    step();
    s_axil_wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("w_first_wready_low", 32'(s_axil_wready), 32'd0);
      check("w_first_awready_high", 32'(s_axil_awready), 32'd1);
      check("w_first_no_bvalid", 32'(s_axil_bvalid), 32'd0);
      if (c < 2) step();
    end
    s_axil_awvalid = 1'b1; s_axil_awaddr = 25'h008;
    step();
    s_axil_awvalid = 1'b0;
    collect_b(pulse);
    check("reg2_low_byte", regs_out[95:64], 32'h000000AA);
    check_regs("regs_t2");

    // partial strobes and an empty strobe that still pulses
    do_write(25'h004, 32'h11223344, 4'b0101);
    do_write(25'h006, 32'hFFFFFFFF, 4'b0000);
    do_write(25'h03C, 32'hA5A5_0F0F, 4'b1100);
    check_regs("regs_t3");
    do_read(25'h004, 0, 1'b1, rd);
    do_read(25'h03C, 2, 1'b1, rd);

    // status word with a stalled R channel
    status_in = 32'h12345678;
    do_read(25'h040, 5, 1'b1, rd);

    // RO and unmapped accesses
    do_write(25'h044, 32'h0BAD0BAD, 4'hF);
    do_write(25'h040, 32'h0BAD0BAD, 4'hF);
    do_write(25'h100, 32'h0BAD0BAD, 4'hF);
    check_regs("regs_t4");
    do_read(25'h100, 0, 1'b1, rd);

    // cycle counter, AR edges ten cycles apart
    do_read(25'h044, 0, 1'b0, c1);
    repeat (8) @(posedge clock);
    #1;
    do_read(25'h044, 0, 1'b0, c2);
    check("counter_delta", c2 - c1, 32'd10);

    // reset with only AW held
    s_axil_awvalid = 1'b1; s_axil_awaddr = 25'h00C;
    step();
    s_axil_awvalid = 1'b0;
    check("aw_held_awready", 32'(s_axil_awready), 32'd0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    exp_b_q.delete();
    exp_r_q.delete();
    check("rst2_bvalid", 32'(s_axil_bvalid), 32'd0);
    check("rst2_awready", 32'(s_axil_awready), 32'd1);
    check_regs("rst2_regs");
    step();
    step();
    reset = 1'b0;
    step();
    check("rst2_no_bvalid", 32'(s_axil_bvalid), 32'd0);
    do_write(25'h00C, 32'hCAFEF00D, 4'hF);
    do_read(25'h00C, 1, 1'b1, rd);
    check_regs("regs_final");
    check("scoreboard_empty", 32'(exp_b_q.size() + exp_r_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
